// File: rtl/mrv32_mem_arbiter.sv
// Two-requester (I fetch / D load-store) arbiter onto one pulse-protocol memory port; one pending slot per side,
// one transaction outstanding, request->m_valid 2 cycles, excess pulses at a full slot dropped with sticky proto_err.
module mrv32_mem_arbiter #(
  parameter int unsigned ADDR_WIDTH     = 16,
  parameter int unsigned TIMEOUT_CYCLES = 255
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  i_valid,
  input  logic [ADDR_WIDTH-1:0] i_addr,
  input  logic [31:0]           i_wdata,
  input  logic [3:0]            i_wstrb,
  output logic [31:0]           i_rdata,
  output logic                  i_rvalid,
  output logic                  i_err,
  input  logic                  d_valid,
  input  logic [ADDR_WIDTH-1:0] d_addr,
  input  logic [31:0]           d_wdata,
  input  logic [3:0]            d_wstrb,
  output logic [31:0]           d_rdata,
  output logic                  d_rvalid,
  output logic                  d_err,
  output logic                  m_valid,
  output logic [ADDR_WIDTH-1:0] m_addr,
  output logic [31:0]           m_wdata,
  output logic [3:0]            m_wstrb,
  input  logic [31:0]           m_rdata,
  input  logic                  m_rvalid,
  output logic                  busy,
  output logic                  proto_err
);

  typedef enum logic [1:0] {S_IDLE, S_ISSUE, S_WAIT} state_t;

  localparam int unsigned TO_LAST = (TIMEOUT_CYCLES == 0) ? 0 : TIMEOUT_CYCLES - 1;
  localparam logic [15:0] TO_LAST_W = 16'(TO_LAST);

  state_t                state_q, state_d;
  logic                  gnt_q, gnt_d;     // 1 = D side owns the transaction
  logic                  last_q, last_d;
  logic [15:0]           cnt_q, cnt_d;
  logic                  perr_q;

  logic                  i_full_q, d_full_q;
  logic [ADDR_WIDTH-1:0] i_addr_q, d_addr_q;
  logic [31:0]           i_wdata_q, d_wdata_q;
  logic [3:0]            i_wstrb_q, d_wstrb_q;

  logic                  resp_vld, resp_err;
  logic [31:0]           resp_dat;
  logic                  rel_i, rel_d;
  logic                  i_cap, d_cap, i_drop, d_drop, stray;

  always_comb begin
    state_d  = state_q;
    gnt_d    = gnt_q;
    last_d   = last_q;
    cnt_d    = cnt_q;
    m_valid  = 1'b0;
    m_addr   = '0;
    m_wdata  = '0;
    m_wstrb  = '0;
    resp_vld = 1'b0;
    resp_err = 1'b0;
    resp_dat = '0;
    case (state_q)
      S_IDLE: begin
        if (i_full_q || d_full_q) begin
          gnt_d   = (i_full_q && d_full_q) ? ~last_q : d_full_q;
          last_d  = gnt_d;
          state_d = S_ISSUE;
        end
      end
      S_ISSUE: begin
        m_valid = 1'b1;
        m_addr  = gnt_q ? d_addr_q  : i_addr_q;
        m_wdata = gnt_q ? d_wdata_q : i_wdata_q;
        m_wstrb = gnt_q ? d_wstrb_q : i_wstrb_q;
        cnt_d   = '0;
        state_d = S_WAIT;
      end
      S_WAIT: begin
        if (m_rvalid) begin
          resp_vld = 1'b1;
          resp_dat = m_rdata;
          state_d  = S_IDLE;
        end else begin
          // Saturate so a disabled watchdog never wraps the count.
          cnt_d = (cnt_q == 16'hFFFF) ? cnt_q : cnt_q + 16'd1;
          if (TIMEOUT_CYCLES != 0 && cnt_q == TO_LAST_W) begin
            resp_vld = 1'b1;
            resp_err = 1'b1;
            state_d  = S_IDLE;
          end
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  assign rel_i = resp_vld & ~gnt_q;
  assign rel_d = resp_vld &  gnt_q;

  assign i_rvalid = rel_i;
  assign i_rdata  = rel_i ? resp_dat : 32'd0;
  assign i_err    = rel_i & resp_err;
  assign d_rvalid = rel_d;
  assign d_rdata  = rel_d ? resp_dat : 32'd0;
  assign d_err    = rel_d & resp_err;

  // A slot releasing this cycle can accept a new pulse at the same edge.
  assign i_cap  = i_valid & (~i_full_q | rel_i);
  assign d_cap  = d_valid & (~d_full_q | rel_d);
  assign i_drop = i_valid & i_full_q & ~rel_i;
  assign d_drop = d_valid & d_full_q & ~rel_d;
  assign stray  = m_rvalid & (state_q != S_WAIT);

  assign busy      = (state_q != S_IDLE) | i_full_q | d_full_q;
  assign proto_err = perr_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= S_IDLE;
      gnt_q     <= 1'b0;
      last_q    <= 1'b0;
      cnt_q     <= '0;
      perr_q    <= 1'b0;
      i_full_q  <= 1'b0;
      d_full_q  <= 1'b0;
      i_addr_q  <= '0;
      i_wdata_q <= '0;
      i_wstrb_q <= '0;
      d_addr_q  <= '0;
      d_wdata_q <= '0;
      d_wstrb_q <= '0;
    end else begin
      state_q  <= state_d;
      gnt_q    <= gnt_d;
      last_q   <= last_d;
      cnt_q    <= cnt_d;
      perr_q   <= perr_q | i_drop | d_drop | stray;
      i_full_q <= i_cap | (i_full_q & ~rel_i);
      d_full_q <= d_cap | (d_full_q & ~rel_d);
      if (i_cap) begin
        i_addr_q  <= i_addr;
        i_wdata_q <= i_wdata;
        i_wstrb_q <= i_wstrb;
      end
      if (d_cap) begin
        d_addr_q  <= d_addr;
        d_wdata_q <= d_wdata;
        d_wstrb_q <= d_wstrb;
      end
    end
  end

endmodule

// File: doc/mrv32_mem_arbiter.md
Name: mrv32_mem_arbiter

Overview:
- Shares the single request/response port of dual_port_byte_mem between two requesters: instruction fetch (I side) and load/store (D side).
- Each side uses the pulse protocol. valid is high for one cycle with addr/wdata/wstrb. rvalid/rdata returns later.
- The arbiter buffers one pending request per side and keeps one transaction outstanding downstream.
- It routes the response back to the side that owns the transaction. A watchdog converts a lost response into an error response.

Parameters:
- ADDR_WIDTH, 16: byte-address width. The top level ties it to mrv32_pkg::ADDR_WIDTH.
- TIMEOUT_CYCLES, 255: cycles in WAIT without m_rvalid before an error response is returned. 0 disables the watchdog. Legal range 0..65535.

Ports:
- clk  in  1  clock; all logic on the rising edge
- rst  in  1  synchronous active-high reset
- i_valid  in  1  I-side request pulse
- i_addr  in  ADDR_WIDTH  I-side byte address
- i_wdata  in  32  I-side write data
- i_wstrb  in  4  I-side byte strobes; 0 = read
- i_rdata  out  32  I-side response data
- i_rvalid  out  1  I-side response pulse
- i_err  out  1  I-side timeout flag; valid with i_rvalid
- d_valid, d_addr, d_wdata, d_wstrb, d_rdata, d_rvalid, d_err: D-side equivalents; same directions and widths
- m_valid  out  1  memory request pulse
- m_addr  out  ADDR_WIDTH  memory byte address
- m_wdata  out  32  memory write data
- m_wstrb  out  4  memory byte strobes
- m_rdata  in  32  memory response data
- m_rvalid  in  1  memory response; exactly one per accepted request, reads and writes
- busy  out  1  high when state != IDLE or either slot is full
- proto_err  out  1  sticky protocol-violation flag

Behaviour:
- Reset, while rst is high at a clock edge:
  - state=IDLE; both slots empty; last_grant=I, so D wins the first tie; watchdog counter=0; proto_err=0.
  - All outputs are 0.
  - Reset mid-transaction abandons it. A late m_rvalid after reset is a stray.
- Slots (one per side): holds addr/wdata/wstrb plus a full bit.
  - A valid pulse is captured at the clock edge when the slot is empty, or when the slot is released in that same cycle.
  - A pulse arriving at a full, non-releasing slot is dropped and sets proto_err.
- FSM states:
  - IDLE: if any slot is full, register grant and go to ISSUE. If both are full, grant the side != last_grant. Set last_grant=grant. A request captured in cycle T is first seen in IDLE at T+1.
  - ISSUE: m_valid=1 for exactly one cycle. m_addr/m_wdata/m_wstrb come from the granted slot. Clear the counter; go to WAIT.
  - WAIT, with m_rvalid: drive the granted side's rvalid=1 and rdata=m_rdata in the same cycle (combinational), err=0. Release the slot; go to IDLE.
  - WAIT, without m_rvalid: counter increments. With TIMEOUT_CYCLES!=0 and counter==TIMEOUT_CYCLES-1: granted side gets rvalid=1, rdata=0, err=1. Release the slot; go to IDLE.
  - Simultaneous m_rvalid and timeout: m_rvalid wins, err=0.
- Outputs when not active:
  - m_addr/m_wdata/m_wstrb are 0 outside ISSUE.
  - i_/d_ rdata, rvalid and err are 0 except during the response cycle.
- Stray m_rvalid (any state but WAIT): ignored, sets proto_err.
- Minimum latency, with m_rvalid arriving one cycle after m_valid:
  - request at T, m_valid at T+2, response at T+3.
  - Back-to-back request from the same side in the response cycle R: m_valid again at R+2.
- No cross-side ordering guarantees beyond the arbitration rule. Addresses are passed unmodified.
- Counter is 16 bits and never wraps within a transaction.

Test Plan:
- Single read: i_valid@T, i_addr=0x0010, wstrb=0. Expect m_valid@T+2 with m_addr=0x0010. Memory returns 0x00500093 @T+3: i_rvalid=1, i_rdata=0x00500093 that cycle; d_rvalid stays 0.
- Tie: i_valid and d_valid both @T (D write 0xDEADBEEF, wstrb=0xF, addr 0x0100). Expect D issued first, then I. A second tie after that is granted to D, because last_grant=I.
- Back-to-back: I re-requests addr 0x0014 in its response cycle R. Expect m_valid@R+2; no proto_err.
- Overflow: d_valid pulses twice while the first D request is still in WAIT. Expect proto_err=1 and the second request dropped. Only one m_valid reaches memory for D.
- Timeout: TIMEOUT_CYCLES=4, memory never responds. Expect d_rvalid=1, d_err=1, d_rdata=0 exactly 4 cycles after m_valid. A late m_rvalid then sets proto_err and produces no rvalid on either side.
- Reset mid-WAIT: rst high one cycle during WAIT. Expect busy=0 and slots empty. A subsequent i_valid completes normally.
